// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for serial_subtractor (flag signals exist with SERIAL_SUB_FLAGS_EN).
interface serial_subtractor_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             overflow;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             lt;
`endif
  modport master (
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, D, bout, overflow
`ifdef SERIAL_SUB_FLAGS_EN
    , input zero, lt
`endif
  );
  modport slave (
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, D, bout, overflow
`ifdef SERIAL_SUB_FLAGS_EN
    , output zero, lt
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: D = A - B - bin, CHUNK bits per cycle with a registered borrow chain; SERIAL_SUB_FLAGS_EN adds zero/lt outputs.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q, d_nx;
  logic [IW-1:0]    idx_q;
  logic             carry_q, bout_q, ovf_q;
  logic [CHUNK-1:0] sum;
  logic             c_out, last, ovf_nx;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero_q, lt_q;
`endif

  // Subtraction as A + ~B + carry, where the carry starts as ~bin.
  always_comb begin
    {c_out, sum} = {1'b0, a_q[int'(idx_q)*CHUNK +: CHUNK]}
                 + {1'b0, ~b_q[int'(idx_q)*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_q};
    d_nx = d_q;
    d_nx[int'(idx_q)*CHUNK +: CHUNK] = sum;
    last = idx_q == IW'(NCH - 1);
    ovf_nx = (a_q[MSB] != b_q[MSB]) && (d_nx[MSB] != a_q[MSB]);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE ? (bus.in_valid ? RUN : IDLE)
            : state_q == RUN  ? (last ? DONE : RUN)
            : (bus.out_ready ? IDLE : DONE);
  end

  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.D         = d_q;
    bus.bout      = bout_q;
    bus.overflow  = ovf_q;
`ifdef SERIAL_SUB_FLAGS_EN
    bus.zero      = zero_q;
    bus.lt        = lt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else if (state_q == IDLE && bus.in_valid) begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      carry_q <= ~bus.bin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      d_q     <= d_nx;
      carry_q <= c_out;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        bout_q <= ~c_out;
        ovf_q  <= ovf_nx;
`ifdef SERIAL_SUB_FLAGS_EN
        zero_q <= d_nx == '0;
        lt_q   <= d_nx[MSB] ^ ovf_nx;
`endif
      end
    end
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle signed subtractor computing D = A - B - bin, CHUNK bits per cycle, with a borrow chain carried between cycles. It is the inverse-direction companion to the team's combinational adders: it is area-lean and sits behind a valid/ready producer in datapaths where subtraction latency is tolerable. Results are held until the downstream consumer accepts them.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits processed per RUN cycle; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands presented.
in_ready  output  1  block can accept operands.
A  input  WIDTH  minuend, signed two's complement.
B  input  WIDTH  subtrahend, signed two's complement.
bin  input  1  borrow-in.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
D  output  WIDTH  signed difference.
bout  output  1  borrow-out: unsigned A < B + bin.
overflow  output  1  signed overflow.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: out_valid=0, D=0, bout=0, overflow=0, in_ready=1, state=IDLE, chunk index=0.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid at a clock edge.
  - Capture A, B and bin at that edge.
  - Initialise the internal carry to ~bin and the chunk index to 0.
- RUN: each cycle processes chunk k = bits [k*CHUNK +: CHUNK].
  - sum = A_k + ~B_k + carry.
  - Write the sum into D_k and register the carry-out.
  - After chunk WIDTH/CHUNK-1, go to DONE.
- Latency: out_valid rises exactly WIDTH/CHUNK cycles after the accepting edge. Default is 4 cycles.
- DONE: D, bout and overflow are stable and held while out_ready=0.
  - On out_valid && out_ready, go to IDLE.
  - No input is accepted in that cycle, so there is a one-cycle bubble between operations.
- bout = ~final carry.
- overflow = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the captured operands.
- Inputs are ignored when in_ready=0; changes to A, B or bin during RUN/DONE have no effect.
- D is updated chunk-wise during RUN; consumers only sample D when out_valid=1.
- Reset mid-operation (RUN or DONE):
  - The operation is aborted and the result is discarded.
  - All outputs return to reset values on the next edge.
  - in_valid in the same cycle as rst is ignored.
- CHUNK == WIDTH: a single RUN cycle, latency 1.

Optional Feature:
SERIAL_SUB_FLAGS_EN
- Defined: two extra output ports, each reset to 0 and held in DONE alongside D.
  - zero (1): D == 0.
  - lt (1): signed A < B + bin, equal to D[MSB] ^ overflow.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- A=5, B=3, bin=0, accepted at edge T -> out_valid at T+4; D=2, bout=0, overflow=0 (flags: zero=0, lt=0).
- A=0, B=1, bin=0 -> D=0xFFFFFFFF, bout=1, overflow=0 (lt=1).
- A=0x80000000, B=1 -> D=0x7FFFFFFF, bout=0, overflow=1 (lt=1). Also A=0x7FFFFFFF, B=0xFFFFFFFF -> D=0x80000000, overflow=1, bout=1.
- A=10, B=3, bin=1 -> D=6, bout=0. Also A=7, B=7, bin=0 -> D=0, bout=0 (zero=1).
- Backpressure: hold out_ready=0 for 6 cycles after out_valid.
  - D, bout and overflow stay stable; in_ready=0; a new in_valid is ignored.
  - Raise out_ready: next cycle in_ready=1 and out_valid=0.
- Assert rst for 1 cycle at RUN cycle 2 -> next cycle out_valid=0, D=0, in_ready=1. A new operation 9-4 then yields D=5 at latency 4.
